// File: rtl/alu_slice_seq.sv
// Slice-serial ALU: decodes opsel/mode into B-operand transform and initial carry,
// then computes the result SLICE bits per clock with a registered inter-slice carry.
module alu_slice_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opsel,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("alu_slice_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_opsel;
    logic             r_mode;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_op;
    logic [WIDTH-1:0] w_b_op;
    logic             w_cin0;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sum_ext;
    logic [SLICE-1:0] w_logic_sl;
    logic [SLICE-1:0] w_res_sl;
    logic             w_carry_msb;
    logic [WIDTH-1:0] w_result_next;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);

    // Operand transform applied once at accept; logic mode keeps the raw operands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_a_op = a;
        w_b_op = b;
        w_cin0 = 1'b0;
        if (!mode) begin
            case (opsel)
                3'b000: w_cin0 = 1'b0;
                3'b001: w_cin0 = cin_ext;
                3'b010: begin w_b_op = ~b;         w_cin0 = 1'b1;    end
                3'b011: begin w_b_op = ~b;         w_cin0 = cin_ext; end
                3'b100: begin w_b_op = '0;         w_cin0 = 1'b1;    end
                3'b101: begin w_b_op = '1;         w_cin0 = 1'b0;    end
                3'b110: begin w_a_op = '0; w_b_op = ~b; w_cin0 = 1'b1; end
                default: begin w_b_op = '0;        w_cin0 = 1'b0;    end
            endcase
        end
    end

    always_comb begin
        w_a_sl    = r_a[r_idx*SLICE +: SLICE];
        w_b_sl    = r_b[r_idx*SLICE +: SLICE];
        w_sum_ext = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
        case (r_opsel)
            3'b000:  w_logic_sl = w_a_sl & w_b_sl;
            3'b001:  w_logic_sl = w_a_sl | w_b_sl;
            3'b010:  w_logic_sl = w_a_sl ^ w_b_sl;
            3'b011:  w_logic_sl = ~w_a_sl;
            default: w_logic_sl = w_a_sl;
        endcase
        w_res_sl = r_mode ? w_logic_sl : w_sum_ext[SLICE-1:0];
        // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out of the XOR.
        w_carry_msb = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sum_ext[SLICE-1];
        w_result_next = r_result;
        w_result_next[r_idx*SLICE +: SLICE] = w_res_sl;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // NOTE: operand, carry and index registers carry no reset: they are always loaded at accept before RUN reads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a     <= w_a_op;
            r_b     <= w_b_op;
            r_opsel <= opsel;
            r_mode  <= mode;
            r_carry <= w_cin0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_carry <= w_sum_ext[SLICE];
            if (!w_last) r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_result <= w_result_next;
            if (w_last) begin
                r_cout <= ~r_mode & w_sum_ext[SLICE];
                r_ovf  <= ~r_mode & (w_carry_msb ^ w_sum_ext[SLICE]);
                r_zero <= (w_result_next == '0);
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Bench for alu_slice_seq: scoreboarded operations on an 8-bit-slice instance,
// plus a full-width-slice instance for single-cycle latency.
module tb_alu_slice_seq;

    localparam int WIDTH  = 32;
    localparam int NSLICE = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, mode, cin_ext, out_valid, out_ready, cout, ovf, zero;
    logic [2:0]  opsel;
    logic [31:0] a, b, result;

    logic        in_valid_w, in_ready_w, out_valid_w, cout_w, ovf_w, zero_w;
    logic [31:0] a_w, b_w, result_w;

    alu_slice_seq #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opsel(opsel), .mode(mode), .a(a), .b(b), .cin_ext(cin_ext),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    alu_slice_seq #(.WIDTH(WIDTH), .SLICE(32)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .opsel(3'b000), .mode(1'b0), .a(a_w), .b(b_w), .cin_ext(1'b0),
        .out_valid(out_valid_w), .out_ready(1'b1), .result(result_w),
        .cout(cout_w), .ovf(ovf_w), .zero(zero_w)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full-width add; overflow from a sign-extended 34-bit sum leaving the 32-bit range.
    function automatic exp_t model(input logic [2:0] op, input logic md,
                                   input logic [31:0] av, input logic [31:0] bv, input logic ci);
        exp_t               e;
        logic [31:0]        ap, bp;
        logic               c0;
        logic [32:0]        full;
        logic signed [33:0] s;
        e = '0;
        if (md) begin
            case (op)
                3'b000:  e.res = av & bv;
                3'b001:  e.res = av | bv;
                3'b010:  e.res = av ^ bv;
                3'b011:  e.res = ~av;
                default: e.res = av;
            endcase
        end else begin
            ap = av; bp = bv; c0 = 1'b0;
            case (op)
                3'b000: begin end
                3'b001: c0 = ci;
                3'b010: begin bp = ~bv; c0 = 1'b1; end
                3'b011: begin bp = ~bv; c0 = ci;   end
                3'b100: begin bp = 32'd0; c0 = 1'b1; end
                3'b101: bp = 32'hFFFF_FFFF;
                3'b110: begin ap = 32'd0; bp = ~bv; c0 = 1'b1; end
                default: bp = 32'd0;
            endcase
            full  = {1'b0, ap} + {1'b0, bp} + {32'd0, c0};
            e.res = full[31:0];
            e.c   = full[32];
            s     = $signed({{2{ap[31]}}, ap}) + $signed({{2{bp[31]}}, bp}) + $signed({33'd0, c0});
            e.v   = !(s[33:31] == 3'b000 || s[33:31] == 3'b111);
        end
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic md, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci, input int stall, input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        opsel = op; mode = md; a = av; b = bv; cin_ext = ci; in_valid = 1'b1;
        sb_q.push_back(model(op, md, av, bv, ci));
        @(posedge clk);
        @(negedge clk);
        in_valid = (stall > 0);
        opsel = 3'($urandom); mode = 1'($urandom); a = $urandom; b = $urandom; cin_ext = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(NSLICE));
        for (int i = 0; i < stall; i++) begin
            check({tag, ".hold_result"}, result, sb_q[0].res);
            check({tag, ".hold_flags"}, {29'd0, cout, ovf, zero}, {29'd0, sb_q[0].c, sb_q[0].v, sb_q[0].z});
            check({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb_q.pop_front();
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"}, result, e.res);
        check({tag, ".cout"}, 32'(cout), 32'(e.c));
        check({tag, ".ovf"}, 32'(ovf), 32'(e.v));
        check({tag, ".zero"}, 32'(zero), 32'(e.z));
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_result_hold"}, result, e.res);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opsel = '0; mode = 1'b0;
        a = '0; b = '0; cin_ext = 1'b0; in_valid_w = 1'b0; a_w = '0; b_w = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        check("rst.zero", 32'(zero), 32'd0);

        run_op(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "add_wrap");
        run_op(3'b010, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 0, "sub_ovf");
        run_op(3'b010, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 0, "xor");
        run_op(3'b001, 1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0, "adc_ovf");
        run_op(3'b011, 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 0, "sbb");
        run_op(3'b011, 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b1, 0, "sbb_nb");
        run_op(3'b100, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0, "inc");
        run_op(3'b101, 1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0, 0, "dec");
        run_op(3'b110, 1'b0, 32'hAAAA_AAAA, 32'h0000_0001, 1'b0, 0, "neg");
        run_op(3'b111, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0, "pass");
        run_op(3'b000, 1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 0, "and");
        run_op(3'b001, 1'b1, 32'hF000_0001, 32'h0000_F000, 1'b0, 0, "or");
        run_op(3'b011, 1'b1, 32'h0F0F_0000, 32'h1111_1111, 1'b1, 0, "not");
        run_op(3'b110, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0, "lpass");
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 0, "rand");
        run_op(3'b000, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 5, "bp");

        // Reset lands while the third slice is being computed.
        @(negedge clk);
        opsel = 3'b000; mode = 1'b0; a = 32'h1122_3344; b = 32'h0101_0101; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.result", result, 32'd0);
        run_op(3'b001, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, 0, "after_rst");
        check("after_rst.value", result, 32'd3);

        @(negedge clk);
        a_w = 32'hFFFF_FFFF; b_w = 32'h0000_0001; in_valid_w = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_w = 1'b0;
        lat = 0;
        while (!out_valid_w && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("wide.latency", 32'(lat), 32'd1);
        check("wide.result", result_w, 32'd0);
        check("wide.flags", {29'd0, cout_w, ovf_w, zero_w}, {29'd0, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        check("wide.in_ready", 32'(in_ready_w), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
